// File: rtl/otter_mmio_ctrl.sv
// -----------------------------------------------------------------------------
// otter_mmio_ctrl
//   Memory-mapped I/O controller between the OTTER I/O bus and board devices.
//   It provides a bank of write/readback output registers, double-flop
//   synchronised switches and debounced buttons. Button presses latch sticky
//   status flags (write-1-to-clear), and a per-button mask gates them into a
//   registered, level-sensitive interrupt for the MCU.
//
//   Register map (exact word addresses; nothing else decodes):
//     IN_BASE+0x0   RO   switches after synchronisation
//     IN_BASE+0x4   RO   debounced buttons
//     IN_BASE+0x8   W1C  sticky press flags
//     IN_BASE+0xC   RW   interrupt mask
//     OUT_BASE+4k   RW   output register k, k = 0..N_OUT-1
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   iobus_addr  bus address from the MCU
//   iobus_out   bus write data from the MCU
//   iobus_wr    one-cycle write strobe
//   iobus_in    combinational read data back to the MCU
//   switches    raw asynchronous switch inputs
//   buttons     raw asynchronous button inputs
//   out_regs    output registers, register k at [k*OUT_W +: OUT_W]
//   intr        registered interrupt request
// -----------------------------------------------------------------------------
module otter_mmio_ctrl #(
  parameter logic [31:0] IN_BASE   = 32'h1100_8000,
  parameter logic [31:0] OUT_BASE  = 32'h1100_C000,
  parameter int unsigned N_OUT     = 4,
  parameter int unsigned OUT_W     = 16,
  parameter int unsigned IN_W      = 16,
  parameter int unsigned N_BTN     = 5,
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            iobus_addr,
  input  logic [31:0]            iobus_out,
  input  logic                   iobus_wr,
  output logic [31:0]            iobus_in,
  input  logic [IN_W-1:0]        switches,
  input  logic [N_BTN-1:0]       buttons,
  output logic [N_OUT*OUT_W-1:0] out_regs,
  output logic                   intr
);

  // Sized so DB_CYCLES itself is representable; the counter never exceeds
  // DB_CYCLES-1 because it clears on the edge that accepts the new level.
  localparam int unsigned      CNT_W    = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [IN_W-1:0]  sw_meta, sw_sync;
  logic [N_BTN-1:0] btn_meta, btn_sync;
  logic [N_BTN-1:0] btn_db, btn_db_nxt;
  logic [CNT_W-1:0] cnt     [N_BTN];
  logic [CNT_W-1:0] cnt_nxt [N_BTN];
  logic [N_BTN-1:0] status, status_nxt;
  logic [N_BTN-1:0] mask;
  logic [OUT_W-1:0] out_q   [N_OUT];

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic             sel_sw, sel_btn, sel_stat, sel_mask;
  logic [N_OUT-1:0] sel_out;

  always_comb begin
    sel_sw   = (iobus_addr == IN_BASE);
    sel_btn  = (iobus_addr == IN_BASE + 32'h4);
    sel_stat = (iobus_addr == IN_BASE + 32'h8);
    sel_mask = (iobus_addr == IN_BASE + 32'hC);
    for (int k = 0; k < N_OUT; k++) begin
      sel_out[k] = (iobus_addr == OUT_BASE + 32'(4 * k));
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux: zero latency, unused upper bits and unmapped addresses read 0
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves it unassigned and no latch is inferred.
    iobus_in = '0;
    if (sel_sw)   iobus_in[IN_W-1:0]  = sw_sync;
    if (sel_btn)  iobus_in[N_BTN-1:0] = btn_db;
    if (sel_stat) iobus_in[N_BTN-1:0] = status;
    if (sel_mask) iobus_in[N_BTN-1:0] = mask;
    for (int k = 0; k < N_OUT; k++) begin
      if (sel_out[k]) iobus_in[OUT_W-1:0] = out_q[k];
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce: a button's accepted level changes only after DB_CYCLES
  // consecutive edges on which the synchronised input disagrees with it.
  // ---------------------------------------------------------------------------
  always_comb begin
    btn_db_nxt = btn_db;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_nxt[i] = '0;
      if (btn_sync[i] != btn_db[i]) begin
        if (cnt[i] == CNT_LAST) begin
          btn_db_nxt[i] = btn_sync[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Sticky flags: a press (debounced rising edge) is ORed in after the W1C
  // clear, so a press landing on the same edge as a clear is never lost.
  always_comb begin
    status_nxt = status;
    if (iobus_wr && sel_stat) begin
      status_nxt = status_nxt & ~iobus_out[N_BTN-1:0];
    end
    status_nxt = status_nxt | (btn_db_nxt & ~btn_db);
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      btn_meta <= '0;
      btn_sync <= '0;
      btn_db   <= '0;
      status   <= '0;
      mask     <= '0;
      intr     <= 1'b0;
      for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
    end else begin
      sw_meta  <= switches;
      sw_sync  <= sw_meta;
      btn_meta <= buttons;
      btn_sync <= btn_meta;
      btn_db   <= btn_db_nxt;
      status   <= status_nxt;
      for (int i = 0; i < N_BTN; i++) cnt[i] <= cnt_nxt[i];
      if (iobus_wr && sel_mask) mask <= iobus_out[N_BTN-1:0];
      // Uses the pre-edge status and mask, hence one clock behind them.
      intr     <= |(status & mask);
    end
  end

  // NOTE: the output bank is a small set of individually addressed flops, not
  // a RAM, so it is reset like any other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_OUT; k++) out_q[k] <= '0;
    end else if (iobus_wr) begin
      for (int k = 0; k < N_OUT; k++) begin
        if (sel_out[k]) out_q[k] <= iobus_out[OUT_W-1:0];
      end
    end
  end

  always_comb begin
    out_regs = '0;
    for (int k = 0; k < N_OUT; k++) begin
      out_regs[k*OUT_W +: OUT_W] = out_q[k];
    end
  end

endmodule

// File: tb/tb_otter_mmio_ctrl.sv
// -----------------------------------------------------------------------------
// tb_otter_mmio_ctrl
//   Directed self-checking bench for otter_mmio_ctrl with default parameters.
//   Inputs change 1 time unit after a rising edge; outputs are sampled there
//   too, well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_otter_mmio_ctrl;

  localparam logic [31:0] IN_BASE  = 32'h1100_8000;
  localparam logic [31:0] OUT_BASE = 32'h1100_C000;
  localparam logic [31:0] A_SW     = IN_BASE;
  localparam logic [31:0] A_BTN    = IN_BASE + 32'h4;
  localparam logic [31:0] A_STAT   = IN_BASE + 32'h8;
  localparam logic [31:0] A_MASK   = IN_BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] iobus_addr;
  logic [31:0] iobus_out;
  logic        iobus_wr;
  logic [31:0] iobus_in;
  logic [15:0] switches;
  logic [4:0]  buttons;
  logic [63:0] out_regs;
  logic        intr;

  int n_checks = 0;
  int n_fail   = 0;

  otter_mmio_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .iobus_addr (iobus_addr),
    .iobus_out  (iobus_out),
    .iobus_wr   (iobus_wr),
    .iobus_in   (iobus_in),
    .switches   (switches),
    .buttons    (buttons),
    .out_regs   (out_regs),
    .intr       (intr)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    iobus_addr = addr;
    iobus_out  = data;
    iobus_wr   = 1'b1;
    tick(1);
    iobus_wr   = 1'b0;
    iobus_out  = '0;
  endtask

  task automatic rd_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    iobus_addr = addr;
    #1;
    check(tag, {32'h0, iobus_in}, {32'h0, exp});
  endtask

  initial begin
    rst_n      = 1'b0;
    iobus_addr = '0;
    iobus_out  = '0;
    iobus_wr   = 1'b0;
    switches   = '0;
    buttons    = '0;

    // Power-on reset state
    tick(2);
    check("rst_out_regs", out_regs, 64'h0);
    check("rst_intr", {63'h0, intr}, 64'h0);
    rd_check("rst_mask", A_MASK, 32'h0);
    rd_check("rst_stat", A_STAT, 32'h0);
    rd_check("rst_out0", OUT_BASE, 32'h0);
    rst_n = 1'b1;
    tick(1);

    // Output register bank
    bus_write(OUT_BASE + 32'h4, 32'hDEAD_BEEF);
    check("out1_bits", {48'h0, out_regs[31:16]}, 64'hBEEF);
    rd_check("out1_read", OUT_BASE + 32'h4, 32'h0000_BEEF);
    bus_write(OUT_BASE, 32'h1111_2222);
    bus_write(OUT_BASE + 32'hC, 32'h0000_00C3);
    check("out_all", out_regs, 64'h00C3_0000_BEEF_2222);
    rd_check("out3_read", OUT_BASE + 32'hC, 32'h0000_00C3);
    bus_write(OUT_BASE + 32'h10, 32'h5555_5555);
    check("out_unmapped_nochg", out_regs, 64'h00C3_0000_BEEF_2222);
    rd_check("out_unmapped_read", OUT_BASE + 32'h10, 32'h0);
    rd_check("in_unmapped_read", IN_BASE + 32'h10, 32'h0);
    bus_write(A_BTN, 32'hFFFF_FFFF);
    rd_check("ro_btn_ignored", A_BTN, 32'h0);

    // Switch synchroniser: visible exactly two edges later
    switches = 16'hA5A5;
    rd_check("sw_edge0", A_SW, 32'h0);
    tick(1);
    rd_check("sw_edge1", A_SW, 32'h0);
    tick(1);
    rd_check("sw_edge2", A_SW, 32'h0000_A5A5);

    // Debounce: 3-clock glitch rejected
    buttons[2] = 1'b1;
    tick(3);
    buttons[2] = 1'b0;
    tick(8);
    rd_check("glitch_btn", A_BTN, 32'h0);
    rd_check("glitch_stat", A_STAT, 32'h0);

    // Debounce: held long enough (2 sync + 4 debounce edges)
    buttons[2] = 1'b1;
    tick(5);
    rd_check("hold5_btn", A_BTN, 32'h0);
    tick(1);
    rd_check("hold6_btn", A_BTN, 32'h0000_0004);
    rd_check("hold6_stat", A_STAT, 32'h0000_0004);
    buttons[2] = 1'b0;
    tick(10);
    rd_check("release_btn", A_BTN, 32'h0);
    rd_check("release_stat_sticky", A_STAT, 32'h0000_0004);

    // Mask and interrupt timing; upper write data ignored
    bus_write(A_MASK, 32'hFFFF_FFE4);
    rd_check("mask_read", A_MASK, 32'h0000_0004);
    check("intr_lag", {63'h0, intr}, 64'h0);
    tick(1);
    check("intr_set", {63'h0, intr}, 64'h1);
    bus_write(A_STAT, 32'h0000_0004);
    rd_check("w1c_stat", A_STAT, 32'h0);
    check("intr_hold", {63'h0, intr}, 64'h1);
    tick(1);
    check("intr_clr", {63'h0, intr}, 64'h0);

    // W1C clear on the same edge as a debounced press: press wins
    bus_write(A_MASK, 32'h0000_0001);
    buttons[0] = 1'b1;
    tick(5);
    bus_write(A_STAT, 32'h0000_0001);
    rd_check("collide_btn", A_BTN, 32'h0000_0001);
    rd_check("collide_stat", A_STAT, 32'h0000_0001);
    check("collide_intr_lag", {63'h0, intr}, 64'h0);
    tick(1);
    check("collide_intr", {63'h0, intr}, 64'h1);

    // Mid-run asynchronous reset with pending interrupt, button still held
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_regs", out_regs, 64'h0);
    check("mid_rst_intr", {63'h0, intr}, 64'h0);
    rd_check("mid_rst_stat", A_STAT, 32'h0);
    rd_check("mid_rst_mask", A_MASK, 32'h0);
    rd_check("mid_rst_out1", OUT_BASE + 32'h4, 32'h0);
    rd_check("mid_rst_btn", A_BTN, 32'h0);
    rd_check("mid_rst_sw", A_SW, 32'h0);
    tick(1);
    rst_n = 1'b1;

    // Held button re-debounces after reset release
    tick(5);
    rd_check("post_rst_stat5", A_STAT, 32'h0);
    rd_check("post_rst_sw", A_SW, 32'h0000_A5A5);
    tick(1);
    rd_check("post_rst_stat6", A_STAT, 32'h0000_0001);
    check("post_rst_intr_masked", {63'h0, intr}, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
